// File: rtl/bram_sdp_param.sv
// Simple-dual-port RAM: masked write port, 1- or 2-cycle read port, read-first/write-first collisions.
// Optional per-word even parity with error injection, enabled by defining BRAM_SDP_PARITY_EN.
module bram_sdp_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int RD_LAT    = 1,
    parameter int WR_FIRST  = 0,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wclke,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mask,
    input  logic              rclke,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
`ifdef BRAM_SDP_PARITY_EN
    input  logic              par_inj,
    output logic              par_err,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);

`ifdef BRAM_SDP_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("RD_LAT must be 1 or 2");
    end

    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    // Power-up image; parity (when present) is made consistent with the data.
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DATA_W-1:0] v;
            v = (INIT_MODE == 1) ? DATA_W'(i) : '0;
`ifdef BRAM_SDP_PARITY_EN
            m[i] = {^v, v};
`else
            m[i] = v;
`endif
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    logic              w_in, r_in, wr_en, rd_hit, collide;
    logic [IDX_W-1:0]  wi, ri;
    logic [DATA_W-1:0] merged;
    logic [WORD_W-1:0] old_w, new_w, rd_word_d;
    logic [WORD_W-1:0] stg_q, out_q;
    logic              stg_vld_q, vld_q;

    assign w_in    = ({1'b0, waddr} < DEPTH_C);
    assign r_in    = ({1'b0, raddr} < DEPTH_C);
    assign wi      = waddr[IDX_W-1:0];
    assign ri      = raddr[IDX_W-1:0];
    assign wr_en   = rst_n & wclke & we & w_in;
    assign rd_hit  = rclke & re;
    assign collide = wr_en & (waddr == raddr);

    assign old_w  = mem_q[wi];
    assign merged = (old_w[DATA_W-1:0] & mask) | (wdata & ~mask);
`ifdef BRAM_SDP_PARITY_EN
    assign new_w  = {(^merged) ^ par_inj, merged};
`else
    assign new_w  = merged;
`endif

    always_comb begin
        rd_word_d = '0;
        if (r_in) begin
            if (WR_FIRST != 0 && collide) rd_word_d = new_w;
            else                          rd_word_d = mem_q[ri];
        end
    end

    // Array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wi] <= new_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q     <= '0;
            stg_vld_q <= 1'b0;
            out_q     <= '0;
            vld_q     <= 1'b0;
        end else begin
            stg_vld_q <= rd_hit;
            if (rd_hit) stg_q <= rd_word_d;
            if (RD_LAT == 2) begin
                vld_q <= stg_vld_q;
                if (stg_vld_q) out_q <= stg_q;
            end else begin
                vld_q <= rd_hit;
                if (rd_hit) out_q <= rd_word_d;
            end
        end
    end

    assign rdata  = out_q[DATA_W-1:0];
    assign rvalid = vld_q;
`ifdef BRAM_SDP_PARITY_EN
    // Even parity over data plus stored bit is zero for a clean word.
    assign par_err = vld_q & (^out_q);
`endif

endmodule

// File: tb/tb_bram_sdp_param.sv
// Scoreboard bench: two RAM configs share stimulus (A: 200 deep, 1-cycle, read-first;
// B: 256 deep, 2-cycle, write-first); expected words are hand-computed constants.
module tb_bram_sdp_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wclke = 1'b1, we = 1'b0, rclke = 1'b1, re = 1'b0;
    logic [7:0]  waddr = '0, raddr = '0;
    logic [15:0] wdata = '0, mask = '0;
    logic [15:0] rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b;
`ifdef BRAM_SDP_PARITY_EN
    logic        par_inj = 1'b0;
    logic        perr_a, perr_b;
`endif

    typedef struct {logic [15:0] d; logic pe; int cyc;} exp_t;
    exp_t qa[$], qb[$];
    int n_vec = 0, n_bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bram_sdp_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .WR_FIRST(0), .INIT_MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .wclke(wclke), .we(we), .waddr(waddr), .wdata(wdata), .mask(mask),
        .rclke(rclke), .re(re), .raddr(raddr),
`ifdef BRAM_SDP_PARITY_EN
        .par_inj(par_inj), .par_err(perr_a),
`endif
        .rdata(rdata_a), .rvalid(rvalid_a));

    bram_sdp_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .WR_FIRST(1), .INIT_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .wclke(wclke), .we(we), .waddr(waddr), .wdata(wdata), .mask(mask),
        .rclke(rclke), .re(re), .raddr(raddr),
`ifdef BRAM_SDP_PARITY_EN
        .par_inj(par_inj), .par_err(perr_b),
`endif
        .rdata(rdata_b), .rvalid(rvalid_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per strobe; data, parity flag and arrival cycle must match.
    always @(negedge clk) begin
        if (rvalid_a) begin
            if (qa.size() == 0) chk("a_unexpected_rvalid", 32'(rvalid_a), 32'd0);
            else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rdata", 32'(rdata_a), 32'(e.d));
                chk("a_latency", cyc, e.cyc);
`ifdef BRAM_SDP_PARITY_EN
                chk("a_par_err", 32'(perr_a), 32'(e.pe));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid_b) begin
            if (qb.size() == 0) chk("b_unexpected_rvalid", 32'(rvalid_b), 32'd0);
            else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rdata", 32'(rdata_b), 32'(e.d));
                chk("b_latency", cyc, e.cyc);
`ifdef BRAM_SDP_PARITY_EN
                chk("b_par_err", 32'(perr_b), 32'(e.pe));
`endif
            end
        end
    end

    // One clock of stimulus; a read pushes the expected word for each DUT with its arrival cycle.
    task automatic step(input bit w, input logic [7:0] wa, input logic [15:0] wd, input logic [15:0] m,
                        input bit inj, input bit r, input logic [7:0] ra,
                        input logic [15:0] ea, input logic [15:0] eb, input bit pe);
        we = w; waddr = wa; wdata = wd; mask = m; re = r; raddr = ra;
`ifdef BRAM_SDP_PARITY_EN
        par_inj = inj;
`else
        if (inj) $display("note: par_inj ignored without parity");
`endif
        if (r) begin
            qa.push_back('{ea, pe, cyc + 1});
            qb.push_back('{eb, pe, cyc + 2});
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
`ifdef BRAM_SDP_PARITY_EN
        par_inj = 1'b0;
`endif
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] ea, input logic [15:0] eb);
        step(0, 8'h00, 16'h0, 16'h0, 0, 1, a, ea, eb, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        step(1, a, d, m, 0, 0, 8'h00, 16'h0, 16'h0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 16'h0, 16'h0, 0, 0, 8'h00, 16'h0, 16'h0, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rdata_a", 32'(rdata_a), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_rdata_b", 32'(rdata_b), 32'd0);
        chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rd(8'h05, 16'h0005, 16'h0005);
        wr(8'h10, 16'hABCD, 16'h00FF);
        rd(8'h10, 16'hAB10, 16'hAB10);
        rd(8'h01, 16'h0001, 16'h0001);
        rd(8'h02, 16'h0002, 16'h0002);
        rd(8'h03, 16'h0003, 16'h0003);

        // Collisions: full write, then a masked one (high byte kept).
        wr(8'h20, 16'h1111, 16'h0000);
        step(1, 8'h20, 16'h2222, 16'h0000, 0, 1, 8'h20, 16'h1111, 16'h2222, 0);
        rd(8'h20, 16'h2222, 16'h2222);
        step(1, 8'h20, 16'h3C3C, 16'hFF00, 0, 1, 8'h20, 16'h2222, 16'h223C, 0);
        rd(8'h20, 16'h223C, 16'h223C);

        // Depth boundary: A has 200 words, B has 256.
        wr(8'hF0, 16'hBEEF, 16'h0000);
        rd(8'hF0, 16'h0000, 16'hBEEF);
        rd(8'hC7, 16'h00C7, 16'h00C7);
        rd(8'hC8, 16'h0000, 16'h00C8);

        // Disabled clock enables: no write, no read strobe.
        wclke = 1'b0;
        wr(8'h30, 16'h7777, 16'h0000);
        wclke = 1'b1;
        rclke = 1'b0;
        re = 1'b1; raddr = 8'h05;
        @(negedge clk);
        re = 1'b0; rclke = 1'b1;
        rd(8'h30, 16'h0030, 16'h0030);

        // Reset while a read is in flight; memory survives.
        wr(8'h40, 16'h5A5A, 16'h0000);
        re = 1'b1; raddr = 8'h40;
        @(posedge clk);
        #1 rst_n = 1'b0; re = 1'b0;
        @(negedge clk);
        chk("midrst_rdata_a", 32'(rdata_a), 32'd0);
        chk("midrst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("midrst_rdata_b", 32'(rdata_b), 32'd0);
        chk("midrst_rvalid_b", 32'(rvalid_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        rd(8'h40, 16'h5A5A, 16'h5A5A);
        idle(2);
        chk("hold_rdata_a", 32'(rdata_a), 32'h5A5A);
        chk("hold_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("hold_rdata_b", 32'(rdata_b), 32'h5A5A);
        chk("hold_rvalid_b", 32'(rvalid_b), 32'd0);

`ifdef BRAM_SDP_PARITY_EN
        step(1, 8'h50, 16'h1234, 16'h0000, 1, 0, 8'h00, 16'h0, 16'h0, 0);
        step(0, 8'h00, 16'h0, 16'h0, 0, 1, 8'h50, 16'h1234, 16'h1234, 1);
        step(1, 8'h50, 16'h1234, 16'h0000, 0, 0, 8'h00, 16'h0, 16'h0, 0);
        step(0, 8'h00, 16'h0, 16'h0, 0, 1, 8'h50, 16'h1234, 16'h1234, 0);
        rd(8'hF0, 16'h0000, 16'hBEEF);
`endif

        idle(5);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: cycle %0d, want completion", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bram_sdp_param.md
Name: bram_sdp_param

Overview:
- Parametrised simple-dual-port block RAM. One write port and one read port share a single clock.
- Generalises the fixed 256x16 RAM primitive in three ways: configurable width and depth, a configurable read pipeline latency, and a selectable read-during-write collision mode.
- Keeps the per-bit write mask and the separate clock-enable/enable pairs on each port. Adds a read-valid strobe.
- Used as the generic storage macro for simulator test netlists and for soft FIFOs.

Parameters:
DATA_W, 16, word width in bits (1..64)
ADDR_W, 8, address width in bits
DEPTH, 256, number of words (<= 2**ADDR_W; need not be a power of two)
RD_LAT, 1, read latency in cycles (1 or 2)
WR_FIRST, 0, same-address collision mode: 0 = read-first (old data), 1 = write-first (new data)
INIT_MODE, 0, power-up contents: 0 = all zero, 1 = mem[i] = i truncated to DATA_W

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
wclke  in  1  write-port clock enable
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
mask  in  DATA_W  per-bit write mask; 1 = bit not written
rclke  in  1  read-port clock enable
re  in  1  read enable
raddr  in  ADDR_W  read address
rdata  out  DATA_W  read data
rvalid  out  1  one-cycle strobe; rdata carries a new read result

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata = 0, rvalid = 0, internal read pipeline stage = 0.
  - Memory array is NOT cleared; contents persist across reset.
  - No write occurs while rst_n is low.
- Write:
  - Occurs on an edge with wclke & we & (waddr < DEPTH).
  - For each bit i: mem[waddr][i] = mask[i] ? old bit : wdata[i].
  - waddr >= DEPTH: write silently dropped.
- Read accept:
  - A read is accepted on edge N when rclke & re.
  - RD_LAT=1: rdata updated and rvalid=1 after edge N.
  - RD_LAT=2: the value is captured into a stage register at edge N and appears on rdata with rvalid=1 after edge N+1.
  - rvalid is 1 for exactly one cycle per accepted read. Back-to-back reads give back-to-back strobes at full throughput.
- Idle read port: rdata holds its last value; rvalid=0.
- Out-of-range read (raddr >= DEPTH): returns all-zero data with rvalid=1.
- Collision (same address, write and read accepted on the same edge):
  - WR_FIRST=0: read returns the pre-write word.
  - WR_FIRST=1: read returns the merged post-write word (masked bits old, unmasked bits new).
- Write followed by a read on a later edge always returns the written data, in either mode.
- Reset mid-operation: any read in flight in the RD_LAT=2 pipeline is discarded, with no rvalid for it after release.
- Reset release: the first accepted read after rst_n rises behaves normally.
- Power-up contents follow INIT_MODE. Simulation initialisation only; reset does not reapply it.

Optional Feature:
- Macro: BRAM_SDP_PARITY_EN.
- When defined:
  - The array stores one extra even-parity bit per word, computed over the full merged word on every write.
  - Adds input par_inj (1 bit). When high during a write, the stored parity bit is inverted.
  - Adds output par_err (1 bit). It is aligned with rvalid and high when the read word's recomputed parity differs from its stored bit. Reset value 0.
  - WR_FIRST collision bypass uses the newly computed parity bit, including inversion by par_inj.
  - Out-of-range reads give par_err=0.
- When undefined: no extra storage and no par_inj/par_err ports; behaviour is otherwise identical.

Test Plan:
- INIT_MODE=1, RD_LAT=1: read addr 0x05 -> rdata=0x0005, rvalid high exactly one cycle after the accept edge.
- Write 0xABCD to 0x10 with mask=0x00FF over old value 0x0010, then read 0x10 -> rdata=0xAB10.
- RD_LAT=2: reads to 1,2,3 on consecutive edges -> rdata 0x0001,0x0002,0x0003 on three consecutive cycles, starting two edges after the first accept; rvalid high for those three cycles.
- Collision on addr 0x20 (old 0x1111, write 0x2222, mask 0) -> WR_FIRST=0 returns 0x1111; WR_FIRST=1 returns 0x2222; a follow-up read returns 0x2222 in both modes.
- RD_LAT=2: assert rst_n low between accept and output -> rdata=0 and rvalid=0, no strobe after release; a written word survives (write 0x5A5A, reset, read -> 0x5A5A).
- DEPTH=200: write to 0xF0 dropped, read of 0xF0 -> rdata=0 with rvalid=1.
- BRAM_SDP_PARITY_EN defined: write with par_inj=1, then read -> par_err=1 with rvalid; rewrite with par_inj=0, then read -> par_err=0.
